// File: rtl/sprite_pkg.sv
// Shared types and helpers for the sprite compositor slice.
// Latency: n/a (package only).
// Backpressure: n/a.
package sprite_pkg;

    localparam int RGB565_W = 16;
    localparam logic [RGB565_W-1:0] KEY_COLOR_DEF = 16'hFFFF;

    // Each slot coordinate occupies a 12-bit field in the packed position buses
    localparam int POS_W   = 12;
    localparam int MAX_SPR = 16;
    localparam int PACK_W  = POS_W * MAX_SPR;

    // Extract slot idx's 12-bit field from a packed coordinate bus
    function automatic logic [POS_W-1:0] coord_at(input logic [PACK_W-1:0] vec, input int idx);
        return POS_W'(vec >> (POS_W * idx));
    endfunction

    // One-hot of the lowest set bit: lowest index wins priority
    function automatic logic [MAX_SPR-1:0] lowest_one(input logic [MAX_SPR-1:0] v);
        return v & (~v + MAX_SPR'(1));
    endfunction

endpackage

// File: rtl/sprite_slot.sv
// One sprite slot: window hit test, texel address, animation frame index, texture RAM.
// Latency: 1 cycle from pixel coordinates to registered hit flag and texel.
// Backpressure: none; load port always accepts, pixel stream cannot be stalled.
module sprite_slot
    import sprite_pkg::*;
#(
    parameter int SPR_W      = 50,
    parameter int SPR_H      = 35,
    parameter int NUM_FRAMES = 3,
    parameter int PIX_W      = RGB565_W,
    parameter int COORD_W    = 11,
    parameter int TEX_DEPTH  = SPR_W * SPR_H * NUM_FRAMES,
    parameter int ADDR_W     = $clog2(TEX_DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pix_valid,
    input  logic [COORD_W-1:0] pixel_x,
    input  logic [COORD_W-1:0] pixel_y,
    input  logic               spr_en,
    input  logic               anim_en,
    input  logic               anim_step,
    input  logic [POS_W-1:0]   pos_x,
    input  logic [POS_W-1:0]   pos_y,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [PIX_W-1:0]   wr_data,
    output logic               hit_q,
    output logic [PIX_W-1:0]   texel
);

    // Two extra bits so x+SPR_W at the right/bottom edge cannot wrap to 0
    localparam int CW     = COORD_W + 2;
    localparam int FIDX_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;

    logic [CW-1:0]     px, py, x0, y0, x1, y1, dx, dy;
    logic              hit;
    logic [ADDR_W-1:0] rd_addr;
    logic [FIDX_W-1:0] frame_idx;
    logic [PIX_W-1:0]  mem [TEX_DEPTH];

    assign px  = CW'(pixel_x);
    assign py  = CW'(pixel_y);
    assign x0  = CW'(pos_x[COORD_W:0]);
    assign y0  = CW'(pos_y[COORD_W:0]);
    assign x1  = x0 + CW'(SPR_W);
    assign y1  = y0 + CW'(SPR_H);
    assign dx  = px - x0;
    assign dy  = py - y0;
    assign hit = spr_en && (px >= x0) && (px < x1) && (py >= y0) && (py < y1);

    // Texel address within the slot; non-hit pixels park the read at word 0
    always_comb begin
        rd_addr = '0;
        if (hit)
            rd_addr = ADDR_W'(int'(frame_idx) * SPR_W * SPR_H + int'(dy) * SPR_W + int'(dx));
    end

    // Animation frame index: advances on divider wrap, freezes (not clears) when disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            frame_idx <= '0;
        else if (anim_step && anim_en)
            frame_idx <= (frame_idx == FIDX_W'(NUM_FRAMES - 1)) ? '0 : frame_idx + FIDX_W'(1);
    end

    // Hit flag travels alongside the RAM read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hit_q <= 1'b0;
        else if (pix_valid)
            hit_q <= hit;
    end

    // Texture RAM: read-before-write, so a same-address collision returns old data
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        if (pix_valid)
            texel <= mem[rd_addr];
    end

endmodule

// File: rtl/sprite_compositor.sv
// N-slot sprite compositor over the background stream with colour key and collision flags.
// Latency: fixed 2 cycles from pix_valid to pixel_out_valid; bubbles hold the last pixel.
// Backpressure: none; load_ready is tied high and the pixel stream is never stalled.
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int NUM_SPR    = 4,
    parameter int SPR_W      = 50,
    parameter int SPR_H      = 35,
    parameter int NUM_FRAMES = 3,
    parameter int ANIM_DIV   = 6,
    parameter int PIX_W      = RGB565_W,
    parameter int COORD_W    = 11,
    parameter logic [PIX_W-1:0] KEY_COLOR = KEY_COLOR_DEF,
    parameter int TEX_DEPTH  = SPR_W * SPR_H * NUM_FRAMES,
    // One spare code point so an out-of-range slot number can be expressed
    parameter int SEL_W      = $clog2(NUM_SPR + 1),
    parameter int ADDR_W     = $clog2(TEX_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pix_valid,
    input  logic [COORD_W-1:0]     pixel_x,
    input  logic [COORD_W-1:0]     pixel_y,
    input  logic [PIX_W-1:0]       bg_data,
    input  logic                   frame_start,
    input  logic [NUM_SPR-1:0]     spr_en,
    input  logic [NUM_SPR-1:0]     spr_anim_en,
    input  logic [NUM_SPR*12-1:0]  spr_x,
    input  logic [NUM_SPR*12-1:0]  spr_y,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic [SEL_W-1:0]       load_sel,
    input  logic [ADDR_W-1:0]      load_addr,
    input  logic [PIX_W-1:0]       load_data,
    output logic                   load_err,
    output logic [PIX_W-1:0]       pixel_out,
    output logic                   pixel_out_valid,
    output logic [NUM_SPR-1:0]     coll_status
);

    localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    logic [DIV_W-1:0]   div_cnt;
    logic               anim_step;
    logic               sel_ok, addr_ok, load_fire;
    logic [NUM_SPR-1:0] wr_en;
    logic [NUM_SPR-1:0] hit_s1, opaque, win, coll_acc;
    logic [PIX_W-1:0]   texel_s1 [NUM_SPR];
    logic [PIX_W-1:0]   bg_s1, pix_next;
    logic               valid_s1, multi;

    assign load_ready = 1'b1;
    assign load_fire  = load_valid && load_ready;
    assign sel_ok     = 32'(load_sel) < NUM_SPR;
    assign addr_ok    = 32'(load_addr) < TEX_DEPTH;
    assign anim_step  = frame_start && (div_cnt == DIV_W'(ANIM_DIV - 1));

    for (genvar i = 0; i < NUM_SPR; i++) begin : g_slot
        assign wr_en[i] = load_fire && sel_ok && addr_ok && (load_sel == SEL_W'(i));

        sprite_slot #(
            .SPR_W      (SPR_W),
            .SPR_H      (SPR_H),
            .NUM_FRAMES (NUM_FRAMES),
            .PIX_W      (PIX_W),
            .COORD_W    (COORD_W),
            .TEX_DEPTH  (TEX_DEPTH),
            .ADDR_W     (ADDR_W)
        ) u_slot (
            .clk        (clk),
            .rst_n      (rst_n),
            .pix_valid  (pix_valid),
            .pixel_x    (pixel_x),
            .pixel_y    (pixel_y),
            .spr_en     (spr_en[i]),
            .anim_en    (spr_anim_en[i]),
            .anim_step  (anim_step),
            .pos_x      (coord_at(PACK_W'(spr_x), i)),
            .pos_y      (coord_at(PACK_W'(spr_y), i)),
            .wr_en      (wr_en[i]),
            .wr_addr    (load_addr),
            .wr_data    (load_data),
            .hit_q      (hit_s1[i]),
            .texel      (texel_s1[i])
        );
    end

    // Opaque slots, lowest-index winner, and the composited pixel
    always_comb begin
        pix_next = bg_s1;
        for (int i = 0; i < NUM_SPR; i++)
            opaque[i] = hit_s1[i] && (texel_s1[i] != KEY_COLOR);
        win = NUM_SPR'(lowest_one(MAX_SPR'(opaque)));
        for (int i = 0; i < NUM_SPR; i++)
            if (win[i])
                pix_next = texel_s1[i];
        multi = valid_s1 && ((opaque & (opaque - NUM_SPR'(1))) != '0);
    end

    // Animation divider counts frame_start pulses 0..ANIM_DIV-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            div_cnt <= '0;
        else if (frame_start)
            div_cnt <= anim_step ? '0 : div_cnt + DIV_W'(1);
    end

    // Background alignment and output register; outputs hold through bubbles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_s1        <= 1'b0;
            bg_s1           <= '0;
            pixel_out_valid <= 1'b0;
            pixel_out       <= '0;
        end else begin
            valid_s1        <= pix_valid;
            pixel_out_valid <= valid_s1;
            if (pix_valid)
                bg_s1 <= bg_data;
            if (valid_s1)
                pixel_out <= pix_next;
        end
    end

    // Collision accumulator; an overlap coincident with frame_start belongs to the new frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll_acc    <= '0;
            coll_status <= '0;
        end else if (frame_start) begin
            coll_status <= coll_acc;
            coll_acc    <= multi ? opaque : '0;
        end else if (multi) begin
            coll_acc    <= coll_acc | opaque;
        end
    end

    // Sticky error for loads aimed outside the slot array or texture depth
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            load_err <= 1'b0;
        else if (load_fire && !(sel_ok && addr_ok))
            load_err <= 1'b1;
    end

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor with hand-computed expectations.
// Latency: checks the 2-cycle pipeline on every pixel.
// Backpressure: none exercised; load_ready is expected high throughout.
module tb_sprite_compositor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pix_valid;
    logic [10:0] pixel_x, pixel_y;
    logic [15:0] bg_data;
    logic        frame_start;
    logic [3:0]  spr_en, spr_anim_en;
    logic [47:0] spr_x, spr_y;
    logic        load_valid;
    logic        load_ready;
    logic [2:0]  load_sel;
    logic [12:0] load_addr;
    logic [15:0] load_data;
    logic        load_err;
    logic [15:0] pixel_out;
    logic        pixel_out_valid;
    logic [3:0]  coll_status;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sprite_compositor dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pix_valid       (pix_valid),
        .pixel_x         (pixel_x),
        .pixel_y         (pixel_y),
        .bg_data         (bg_data),
        .frame_start     (frame_start),
        .spr_en          (spr_en),
        .spr_anim_en     (spr_anim_en),
        .spr_x           (spr_x),
        .spr_y           (spr_y),
        .load_valid      (load_valid),
        .load_ready      (load_ready),
        .load_sel        (load_sel),
        .load_addr       (load_addr),
        .load_data       (load_data),
        .load_err        (load_err),
        .pixel_out       (pixel_out),
        .pixel_out_valid (pixel_out_valid),
        .coll_status     (coll_status)
    );

    task automatic set_slot(input int i, input logic en, input int x, input int y);
        spr_en[i]         = en;
        spr_x[12*i +: 12] = 12'(x);
        spr_y[12*i +: 12] = 12'(y);
    endtask

    task automatic load_word(input int sel, input int addr, input logic [15:0] data);
        @(negedge clk);
        load_valid = 1'b1;
        load_sel   = 3'(sel);
        load_addr  = 13'(addr);
        load_data  = data;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic pulse_fs(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            frame_start = 1'b1;
            @(negedge clk);
            frame_start = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drives one valid pixel and returns the output two cycles later plus the valid one cycle later
    task automatic run_pixel(input int x, input int y, input logic [15:0] bg,
                             output logic [15:0] got, output logic mid_vld, output logic vld);
        @(negedge clk);
        pixel_x   = 11'(x);
        pixel_y   = 11'(y);
        bg_data   = bg;
        pix_valid = 1'b1;
        @(negedge clk);
        pix_valid = 1'b0;
        mid_vld   = pixel_out_valid;
        @(negedge clk);
        got = pixel_out;
        vld = pixel_out_valid;
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests++;
        if ({pixel_out, pixel_out_valid, coll_status, load_err, load_ready} !== {16'h0, 1'b0, 4'h0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL reset_values: got out=%h vld=%b coll=%b err=%b rdy=%b expected 0/0/0/0/1",
                     pixel_out, pixel_out_valid, coll_status, load_err, load_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_window();
        logic [15:0] got;
        logic        mid, vld;
        int          addrs [6] = '{0, 1, 49, 50, 51, 1749};
        foreach (addrs[k]) load_word(0, addrs[k], 16'(addrs[k]));
        spr_en = 4'b0000;
        set_slot(0, 1'b1, 100, 50);

        run_pixel(150, 84, 16'h1234, got, mid, vld);
        tests++;
        if (got !== 16'h1234 || mid !== 1'b0 || vld !== 1'b1) begin
            fails++;
            $display("FAIL right_edge_bg: got %h mid=%b vld=%b expected 1234 mid=0 vld=1", got, mid, vld);
        end
        run_pixel(100, 50, 16'h1234, got, mid, vld);
        tests++;
        if (got !== 16'h0000 || mid !== 1'b0 || vld !== 1'b1) begin
            fails++;
            $display("FAIL texel0_latency: got %h mid=%b vld=%b expected 0000 mid=0 vld=1", got, mid, vld);
        end
        run_pixel(149, 84, 16'h1234, got, mid, vld);
        tests++;
        if (got !== 16'h06D5) begin
            fails++;
            $display("FAIL texel1749: got %h expected 06d5", got);
        end
        run_pixel(101, 51, 16'h1234, got, mid, vld);
        tests++;
        if (got !== 16'h0033) begin
            fails++;
            $display("FAIL texel51: got %h expected 0033", got);
        end
        run_pixel(99, 50, 16'h2222, got, mid, vld);
        tests++;
        if (got !== 16'h2222) begin
            fails++;
            $display("FAIL left_edge_bg: got %h expected 2222", got);
        end
        run_pixel(100, 85, 16'h3333, got, mid, vld);
        tests++;
        if (got !== 16'h3333) begin
            fails++;
            $display("FAIL bottom_edge_bg: got %h expected 3333", got);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (pixel_out !== 16'h3333 || pixel_out_valid !== 1'b0) begin
            fails++;
            $display("FAIL bubble_hold: got %h vld=%b expected 3333 vld=0", pixel_out, pixel_out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] got;
        logic        mid, vld;
        logic [15:0] o1, o2, o3;
        spr_en = 4'b0000;
        set_slot(3, 1'b1, 500, 600);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            load_valid = 1'b1;
            load_sel   = 3'd3;
            load_addr  = 13'(10 + k);
            load_data  = 16'h3A0A + 16'(k);
        end
        @(negedge clk);
        load_valid = 1'b0;
        // three pixels on consecutive cycles, outputs on consecutive cycles
        @(negedge clk);
        pixel_x = 11'd510; pixel_y = 11'd600; bg_data = 16'h0101; pix_valid = 1'b1;
        @(negedge clk);
        pixel_x = 11'd511;
        @(negedge clk);
        pixel_x = 11'd512;
        o1 = pixel_out;
        @(negedge clk);
        pix_valid = 1'b0;
        o2 = pixel_out;
        @(negedge clk);
        o3 = pixel_out;
        tests++;
        if ({o1, o2, o3} !== {16'h3A0A, 16'h3A0B, 16'h3A0C}) begin
            fails++;
            $display("FAIL stream_3px: got %h %h %h expected 3a0a 3a0b 3a0c", o1, o2, o3);
        end
        // write and read the same word in one cycle: old data wins
        @(negedge clk);
        pixel_x = 11'd511; pixel_y = 11'd600; pix_valid = 1'b1;
        load_valid = 1'b1; load_sel = 3'd3; load_addr = 13'd11; load_data = 16'h7777;
        @(negedge clk);
        pix_valid = 1'b0; load_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (pixel_out !== 16'h3A0B) begin
            fails++;
            $display("FAIL rw_same_cycle_old: got %h expected 3a0b", pixel_out);
        end
        run_pixel(511, 600, 16'h0101, got, mid, vld);
        tests++;
        if (got !== 16'h7777) begin
            fails++;
            $display("FAIL rw_after_write: got %h expected 7777", got);
        end
    endtask

    task automatic test_priority();
        logic [15:0] got;
        logic        mid, vld;
        spr_en = 4'b0000;
        set_slot(0, 1'b1, 200, 200);
        set_slot(1, 1'b1, 200, 200);
        load_word(1, 1, 16'hB001);
        run_pixel(201, 200, 16'h4444, got, mid, vld);
        tests++;
        if (got !== 16'h0001) begin
            fails++;
            $display("FAIL prio_slot0: got %h expected 0001", got);
        end
        load_word(0, 1, 16'hFFFF);
        run_pixel(201, 200, 16'h4444, got, mid, vld);
        tests++;
        if (got !== 16'hB001) begin
            fails++;
            $display("FAIL prio_keyed0: got %h expected b001", got);
        end
        load_word(1, 1, 16'hFFFF);
        run_pixel(201, 200, 16'h4444, got, mid, vld);
        tests++;
        if (got !== 16'h4444) begin
            fails++;
            $display("FAIL prio_both_keyed: got %h expected 4444", got);
        end
    endtask

    task automatic test_anim();
        logic [15:0] got;
        logic        mid, vld;
        do_reset();
        spr_en = 4'b0000;
        set_slot(2, 1'b1, 300, 300);
        spr_anim_en = 4'b0100;
        load_word(2, 0, 16'hC000);
        load_word(2, 1750, 16'hC001);
        load_word(2, 3500, 16'hC002);
        pulse_fs(5);
        run_pixel(300, 300, 16'h0000, got, mid, vld);
        tests++;
        if (got !== 16'hC000) begin
            fails++;
            $display("FAIL anim_5_pulses: got %h expected c000", got);
        end
        pulse_fs(1);
        run_pixel(300, 300, 16'h0000, got, mid, vld);
        tests++;
        if (got !== 16'hC001) begin
            fails++;
            $display("FAIL anim_6_pulses: got %h expected c001", got);
        end
        spr_anim_en = 4'b0000;
        pulse_fs(6);
        run_pixel(300, 300, 16'h0000, got, mid, vld);
        tests++;
        if (got !== 16'hC001) begin
            fails++;
            $display("FAIL anim_freeze: got %h expected c001", got);
        end
        spr_anim_en = 4'b0100;
        pulse_fs(6);
        run_pixel(300, 300, 16'h0000, got, mid, vld);
        tests++;
        if (got !== 16'hC002) begin
            fails++;
            $display("FAIL anim_frame2: got %h expected c002", got);
        end
        pulse_fs(6);
        run_pixel(300, 300, 16'h0000, got, mid, vld);
        tests++;
        if (got !== 16'hC000) begin
            fails++;
            $display("FAIL anim_wrap: got %h expected c000", got);
        end
        spr_anim_en = 4'b0000;
    endtask

    task automatic test_collision();
        logic [15:0] got;
        logic        mid, vld;
        do_reset();
        spr_en = 4'b0000;
        set_slot(1, 1'b1, 400, 400);
        set_slot(3, 1'b1, 400, 400);
        load_word(1, 0, 16'h1111);
        load_word(3, 0, 16'h3333);
        load_word(3, 1, 16'h3334);
        pulse_fs(1);
        tests++;
        if (coll_status !== 4'b0000) begin
            fails++;
            $display("FAIL coll_initial: got %b expected 0000", coll_status);
        end
        run_pixel(400, 400, 16'h0000, got, mid, vld);
        tests++;
        if (got !== 16'h1111) begin
            fails++;
            $display("FAIL coll_prio_pixel: got %h expected 1111", got);
        end
        pulse_fs(1);
        tests++;
        if (coll_status !== 4'b1010) begin
            fails++;
            $display("FAIL coll_1_3: got %b expected 1010", coll_status);
        end
        run_pixel(401, 400, 16'h0000, got, mid, vld);
        tests++;
        if (got !== 16'h3334) begin
            fails++;
            $display("FAIL coll_keyed_pixel: got %h expected 3334", got);
        end
        pulse_fs(1);
        tests++;
        if (coll_status !== 4'b0000) begin
            fails++;
            $display("FAIL coll_clear: got %b expected 0000", coll_status);
        end
        // overlap in the same cycle as frame_start goes to the next frame
        @(negedge clk);
        pixel_x = 11'd400; pixel_y = 11'd400; pix_valid = 1'b1;
        @(negedge clk);
        pix_valid = 1'b0; frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        tests++;
        if (coll_status !== 4'b0000) begin
            fails++;
            $display("FAIL coll_same_cycle_now: got %b expected 0000", coll_status);
        end
        pulse_fs(1);
        tests++;
        if (coll_status !== 4'b1010) begin
            fails++;
            $display("FAIL coll_same_cycle_next: got %b expected 1010", coll_status);
        end
    endtask

    task automatic test_edge();
        logic [15:0] got;
        logic        mid, vld;
        spr_en = 4'b0000;
        set_slot(0, 1'b1, 2040, 0);
        run_pixel(5, 10, 16'hABCD, got, mid, vld);
        tests++;
        if (got !== 16'hABCD) begin
            fails++;
            $display("FAIL edge_no_wrap: got %h expected abcd", got);
        end
        set_slot(0, 1'b1, 1900, 0);
        run_pixel(1949, 0, 16'hABCD, got, mid, vld);
        tests++;
        if (got !== 16'h0031) begin
            fails++;
            $display("FAIL edge_last_col: got %h expected 0031", got);
        end
        run_pixel(1950, 0, 16'h5555, got, mid, vld);
        tests++;
        if (got !== 16'h5555) begin
            fails++;
            $display("FAIL edge_past_col: got %h expected 5555", got);
        end
    endtask

    task automatic test_load_err();
        logic [15:0] got;
        logic        mid, vld;
        tests++;
        if (load_err !== 1'b0 || load_ready !== 1'b1) begin
            fails++;
            $display("FAIL err_before: got err=%b rdy=%b expected err=0 rdy=1", load_err, load_ready);
        end
        load_word(4, 0, 16'hDEAD);
        tests++;
        if (load_err !== 1'b1) begin
            fails++;
            $display("FAIL err_bad_sel: got %b expected 1", load_err);
        end
        spr_en = 4'b0000;
        set_slot(0, 1'b1, 100, 50);
        run_pixel(100, 50, 16'h9999, got, mid, vld);
        tests++;
        if (got !== 16'h0000) begin
            fails++;
            $display("FAIL err_no_write: got %h expected 0000", got);
        end
        load_word(0, 0, 16'hBEEF);
        run_pixel(100, 50, 16'h9999, got, mid, vld);
        tests++;
        if (got !== 16'hBEEF || load_err !== 1'b1) begin
            fails++;
            $display("FAIL err_sticky_write_ok: got %h err=%b expected beef err=1", got, load_err);
        end
        do_reset();
        tests++;
        if (load_err !== 1'b0) begin
            fails++;
            $display("FAIL err_reset_clear: got %b expected 0", load_err);
        end
        load_word(0, 5250, 16'h1234);
        tests++;
        if (load_err !== 1'b1) begin
            fails++;
            $display("FAIL err_bad_addr: got %b expected 1", load_err);
        end
    endtask

    task automatic test_reset_midline();
        logic [15:0] got;
        logic        mid, vld;
        spr_en = 4'b0000;
        set_slot(1, 1'b1, 400, 400);
        set_slot(3, 1'b1, 400, 400);
        run_pixel(400, 400, 16'h0000, got, mid, vld);
        pulse_fs(1);
        @(negedge clk);
        pixel_x = 11'd400; pixel_y = 11'd400; bg_data = 16'h0F0F; pix_valid = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (pixel_out !== 16'h1111 || pixel_out_valid !== 1'b1 || coll_status !== 4'b1010 || load_err !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset_state: got out=%h vld=%b coll=%b err=%b expected 1111/1/1010/1",
                     pixel_out, pixel_out_valid, coll_status, load_err);
        end
        #2;
        rst_n = 1'b0;
        pix_valid = 1'b0;
        #1;
        tests++;
        if ({pixel_out, pixel_out_valid, coll_status, load_err} !== 22'h0) begin
            fails++;
            $display("FAIL midline_reset: got out=%h vld=%b coll=%b err=%b expected all 0",
                     pixel_out, pixel_out_valid, coll_status, load_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_pixel(400, 400, 16'h0000, got, mid, vld);
        tests++;
        if (got !== 16'h1111 || mid !== 1'b0 || vld !== 1'b1) begin
            fails++;
            $display("FAIL post_reset_latency: got %h mid=%b vld=%b expected 1111 mid=0 vld=1", got, mid, vld);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        pix_valid   = 1'b0;
        pixel_x     = '0;
        pixel_y     = '0;
        bg_data     = '0;
        frame_start = 1'b0;
        spr_en      = '0;
        spr_anim_en = '0;
        spr_x       = '0;
        spr_y       = '0;
        load_valid  = 1'b0;
        load_sel    = '0;
        load_addr   = '0;
        load_data   = '0;

        test_reset();
        test_window();
        test_back_to_back();
        test_priority();
        test_anim();
        test_collision();
        test_edge();
        test_load_err();
        test_reset_midline();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
